twobit_26x18_mesh_core: RTL and testbench

TWOBIT_26X18_MESH_CORE -- requirements
Module: twobit_26x18_mesh

---
 rtl/twobit_mesh_pkg.sv | 30 +++
 rtl/twobit_26x18_mesh_core_contour_cell.sv | 34 +++
 rtl/twobit_26x18_mesh_core.sv | 87 ++++++++
 tb/tb_twobit_26x18_mesh_core.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/twobit_mesh_pkg.sv
// Shared geometry and algorithm codes for the 26x18 two-bit contour mesh.
//   COLS, ROWS, NPIX : fixed image geometry (pixel p = r*COLS + c)
//   IMG_W            : width of the packed two-bit image bus
//   algo_e           : algorithm select codes
//   NB_*             : bit positions of each neighbour in a cell's 8-bit
//                      neighbour vector (clockwise from north)
package twobit_mesh_pkg;

  localparam int COLS  = 26;
  localparam int ROWS  = 18;
  localparam int NPIX  = COLS * ROWS;
  localparam int IMG_W = 2 * NPIX;

  typedef enum logic [1:0] {
    ALGO_PIX  = 2'b00,
    ALGO_RDBF = 2'b01,
    ALGO_VERT = 2'b10,
    ALGO_RSVD = 2'b11
  } algo_e;

  localparam int NB_N  = 0;
  localparam int NB_NE = 1;
  localparam int NB_E  = 2;
  localparam int NB_SE = 3;
  localparam int NB_S  = 4;
  localparam int NB_SW = 5;
  localparam int NB_W  = 6;
  localparam int NB_NW = 7;

endpackage

// File: rtl/twobit_26x18_mesh_core_contour_cell.sv
// contour_cell: combinational contour decision for one pixel.
//   self_bg : 1 when this pixel is background (its MSB)
//   nbr_bg  : background flags of the 8 neighbours, indexed by NB_*
//   algo    : algorithm select
//   cbit    : contour bit for this pixel
module contour_cell
  import twobit_mesh_pkg::*;
(
  input  logic       self_bg,
  input  logic [7:0] nbr_bg,
  input  algo_e      algo,
  output logic       cbit
);

  logic any4_bg;
  logic any8_bg;
  logic vert_bg;

  always_comb begin
    any4_bg = nbr_bg[NB_N] | nbr_bg[NB_S] | nbr_bg[NB_E] | nbr_bg[NB_W];
    any8_bg = |nbr_bg;
    // A corner needs background on one vertical side and one horizontal side.
    vert_bg = (nbr_bg[NB_N] | nbr_bg[NB_S]) & (nbr_bg[NB_E] | nbr_bg[NB_W]);

    cbit = 1'b0;
    case (algo)
      ALGO_PIX:  cbit = ~self_bg & any4_bg;
      ALGO_RDBF: cbit = ~self_bg & any8_bg;
      ALGO_VERT: cbit = ~self_bg & vert_bg;
      default:   cbit = 1'b0;
    endcase
  end

endmodule

// File: rtl/twobit_26x18_mesh_core.sv
// twobit_26x18_mesh_core: parallel contour extraction over a 26x18 image of
// two-bit pixels. Every pixel is evaluated by its own contour_cell; the
// image is surrounded by a one-pixel background border so edge cells see
// out-of-array neighbours as background.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset, clears contour
//   inp     : image, pixel p at inp[2p+1:2p]
//   high    : capture enable; loads a new contour map on the edge
//   algo    : 00 pixel following, 01 RDBF, 10 vertex following, 11 none
//   contour : registered contour map, bit p for pixel p
module twobit_26x18_mesh_core
  import twobit_mesh_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IMG_W-1:0] inp,
  input  logic             high,
  input  logic [1:0]       algo,
  output logic [NPIX-1:0]  contour
);

  localparam int PW = COLS + 2;
  localparam int PH = ROWS + 2;

  logic [PH*PW-1:0] bg_pad;
  logic [NPIX-1:0]  pix_lsb_unused;
  logic [NPIX-1:0]  cell_out;
  logic [NPIX-1:0]  contour_d;
  logic [NPIX-1:0]  contour_q;
  algo_e            algo_sel;

  assign algo_sel = algo_e'(algo);

  // Padded background map: border ring forced to background, interior
  // taken from each pixel's MSB. The LSB does not affect classification.
  for (genvar pr = 0; pr < PH; pr++) begin : g_pad_r
    for (genvar pc = 0; pc < PW; pc++) begin : g_pad_c
      if (pr == 0 || pr == PH - 1 || pc == 0 || pc == PW - 1) begin : g_border
        assign bg_pad[pr*PW + pc] = 1'b1;
      end else begin : g_inner
        localparam int P = (pr - 1) * COLS + (pc - 1);
        assign bg_pad[pr*PW + pc] = inp[2*P + 1];
        assign pix_lsb_unused[P]  = inp[2*P];
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int C = (r + 1) * PW + (c + 1);
      logic [7:0] nbr;
      assign nbr[NB_N]  = bg_pad[C - PW];
      assign nbr[NB_NE] = bg_pad[C - PW + 1];
      assign nbr[NB_E]  = bg_pad[C + 1];
      assign nbr[NB_SE] = bg_pad[C + PW + 1];
      assign nbr[NB_S]  = bg_pad[C + PW];
      assign nbr[NB_SW] = bg_pad[C + PW - 1];
      assign nbr[NB_W]  = bg_pad[C - 1];
      assign nbr[NB_NW] = bg_pad[C - PW - 1];

      contour_cell u_cell (
        .self_bg (bg_pad[C]),
        .nbr_bg  (nbr),
        .algo    (algo_sel),
        .cbit    (cell_out[r*COLS + c])
      );
    end
  end

  always_comb begin
    contour_d = contour_q;
    if (high) begin
      contour_d = cell_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contour_q <= '0;
    end else begin
      contour_q <= contour_d;
    end
  end

  assign contour = contour_q;

endmodule

// File: tb/tb_twobit_26x18_mesh_core.sv
module tb_twobit_26x18_mesh_core;
  import twobit_mesh_pkg::*;

  typedef logic [NPIX-1:0]  map_t;
  typedef logic [IMG_W-1:0] img_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       high  = 1'b0;
  logic [1:0] algo  = 2'b00;
  img_t       inp   = '1;
  map_t       contour;

  map_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;

  twobit_26x18_mesh_core dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .inp     (inp),
    .high    (high),
    .algo    (algo),
    .contour (contour)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input map_t act, input map_t expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Monitor: every edge out of reset with a pending expectation is checked.
  always @(posedge clk) begin : mon
    map_t  e;
    string n;
    if (rst_n && exp_q.size() > 0) begin
      #1;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check(n, contour, e);
    end
  end

  task automatic apply(input img_t im, input logic [1:0] a, input logic h,
                       input map_t e, input string nm);
    @(negedge clk);
    inp  = im;
    algo = a;
    high = h;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d pending, expected 0", exp_q.size());
    end
  endtask

  function automatic img_t fill(input logic [1:0] v);
    img_t im;
    for (int p = 0; p < NPIX; p++) im[2*p +: 2] = v;
    return im;
  endfunction

  function automatic img_t block_img();
    img_t im;
    im = fill(2'b11);
    for (int r = 2; r <= 4; r++)
      for (int c = 2; c <= 4; c++) im[2*(r*COLS + c) +: 2] = 2'b00;
    return im;
  endfunction

  function automatic map_t frame_map();
    map_t m;
    m = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (r == 0 || r == ROWS - 1 || c == 0 || c == COLS - 1) m[r*COLS + c] = 1'b1;
    return m;
  endfunction

  initial begin
    img_t im_00, im_11, im_blk, im_one;
    map_t m_frame, m_corner, m_perim, m_vert, m_one;

    im_00  = fill(2'b00);
    im_11  = fill(2'b11);
    im_blk = block_img();
    im_one = fill(2'b10);
    im_one[2*135 +: 2] = 2'b01;

    m_frame  = frame_map();
    m_corner = '0;
    m_corner[0] = 1'b1; m_corner[25] = 1'b1; m_corner[442] = 1'b1; m_corner[467] = 1'b1;
    m_perim = '0;
    m_perim[54] = 1'b1; m_perim[55] = 1'b1; m_perim[56] = 1'b1;
    m_perim[80] = 1'b1; m_perim[82] = 1'b1;
    m_perim[106] = 1'b1; m_perim[107] = 1'b1; m_perim[108] = 1'b1;
    m_vert = '0;
    m_vert[54] = 1'b1; m_vert[56] = 1'b1; m_vert[106] = 1'b1; m_vert[108] = 1'b1;
    m_one = '0;
    m_one[135] = 1'b1;

    // Held in reset with capture enabled: edges must not load anything.
    high = 1'b1;
    inp  = im_00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", contour, '0);
    high  = 1'b0;
    rst_n = 1'b1;

    apply(im_11, 2'b00, 1'b1, '0, "all11_pix");
    apply(im_11, 2'b01, 1'b1, '0, "all11_rdbf");
    apply(im_11, 2'b10, 1'b1, '0, "all11_vert");
    apply(im_11, 2'b11, 1'b1, '0, "all11_rsvd");

    apply(im_00, 2'b00, 1'b1, m_frame,  "all00_pix");
    apply(im_00, 2'b01, 1'b1, m_frame,  "all00_rdbf");
    apply(im_00, 2'b10, 1'b1, m_corner, "all00_vert");
    apply(im_00, 2'b11, 1'b1, '0,       "all00_rsvd");

    // Consecutive edges with different algo on the same image.
    apply(im_blk, 2'b00, 1'b1, m_perim, "block_pix");
    apply(im_blk, 2'b01, 1'b1, m_perim, "block_rdbf");
    apply(im_blk, 2'b10, 1'b1, m_vert,  "block_vert");
    apply(im_blk, 2'b11, 1'b1, '0,      "block_rsvd");

    apply(im_one, 2'b01, 1'b1, m_one, "single_rdbf");
    apply(im_11,  2'b01, 1'b0, m_one, "hold_1");
    apply(im_11,  2'b00, 1'b0, m_one, "hold_2");

    apply(im_blk, 2'b10, 1'b1, m_vert, "block_vert_again");
    drain();

    // Asynchronous reset between edges while contour is non-zero.
    rst_n = 1'b0;
    #1;
    check("async_reset", contour, '0);
    high = 1'b1;
    inp  = im_00;
    algo = 2'b00;
    @(posedge clk);
    #1;
    check("reset_ignores_high", contour, '0);
    high  = 1'b0;
    rst_n = 1'b1;

    apply(im_00, 2'b00, 1'b1, m_frame, "post_reset_frame");
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
